// File: rtl/add_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } add_state_t;

  // Chunk-index register width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             c_top_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    c[0] = c_i;
    sum_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i])
               | (a_i[i] & c[i])
               | (b_i[i] & c[i]);
    end
    c_o     = c[CHUNK];
    c_top_o = c[CHUNK-1];
  end

endmodule

// File: rtl/add_multicycle.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first,
// with a start/ready/done handshake and signed overflow.
module add_multicycle
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int KW     = idx_w(NCHUNK);
  localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "add_multicycle: WIDTH must be a multiple of CHUNK");
  end

  add_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] res_d;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] sum;
  logic             c_nxt;
  logic             c_top;

  // Select chunk k of each operand and splice its sum into the result.
  always_comb begin
    idx   = 32'(k_q) * 32'(CHUNK);
    a_sh  = a_q >> idx;
    b_sh  = b_q >> idx;
    a_c   = a_sh[CHUNK-1:0];
    b_c   = b_sh[CHUNK-1:0];
    mask  = WIDTH'({CHUNK{1'b1}}) << idx;
    res_d = (res_q & ~mask) | (WIDTH'(sum) << idx);
  end

  add_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i    (a_c),
    .b_i    (b_c),
    .c_i    (c_q),
    .sum_o  (sum),
    .c_o    (c_nxt),
    .c_top_o(c_top)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= carry_in ^ sub;
            k_q     <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q <= res_d;
          c_q   <= c_nxt;
          k_q   <= k_q + 1'b1;
          if (k_q == LAST) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            out_q   <= res_d;
            cout_q  <= c_nxt;
            ovf_q   <= c_top ^ c_nxt;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign out       = out_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_multicycle.sv
// Scoreboard bench for add_multicycle at CHUNK = 4, 16 and 1.
module tb_add_multicycle;

  typedef struct {
    logic [15:0] o;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        start_v [3];
  logic        ready_v [3];
  logic        done_v  [3];
  logic [15:0] out_v   [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];

  exp_t sbq [3][$];
  int   last_done [3];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    add_multicycle #(
      .WIDTH(16),
      .CHUNK(g == 0 ? 4 : (g == 1 ? 16 : 1))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .carry_in (cin),
      .ready    (ready_v[g]),
      .done     (done_v[g]),
      .out      (out_v[g]),
      .carry_out(cout_v[g]),
      .overflow (ovf_v[g])
    );
  end

  function automatic int nch(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic ci);
    exp_t        e;
    logic [15:0] ye;
    logic [16:0] u;
    int          si;
    ye   = s ? ~y : y;
    u    = {1'b0, x} + {1'b0, ye} + 17'(ci ^ s);
    si   = int'($signed(x)) + int'($signed(ye)) + int'(ci ^ s);
    e.o  = u[15:0];
    e.c  = u[16];
    e.v  = (si > 32767) || (si < -32768);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] o, input logic c,
                              input logic v);
    exp_t e;
    e.o = o; e.c = c; e.v = v; e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("spurious_done%0d", i), 32'(done_v[i]), 32'd0);
          end else begin
            exp_t e;
            e = sbq[i].pop_front();
            chk($sformatf("out%0d", i), 32'(out_v[i]), 32'(e.o));
            chk($sformatf("cout%0d", i), 32'(cout_v[i]), 32'(e.c));
            chk($sformatf("ovf%0d", i), 32'(ovf_v[i]), 32'(e.v));
            chk($sformatf("lat%0d", i), 32'(cyc - e.acc), 32'(nch(i)));
            chk($sformatf("rdy_done%0d", i), 32'(ready_v[i]), 32'd1);
          end
          last_done[i] = cyc;
        end
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input logic ci, input exp_t e,
                       output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("ready_timeout%0d", i), 32'd0, 32'd1);
    a = x; b = y; sub = s; cin = ci;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.acc = cyc;
    sbq[i].push_back(e);
    start_v[i] = 1'b0;
  endtask

  task automatic rnd_op(input int i, output int acc);
    logic [15:0] x, y;
    logic        s, ci;
    x  = 16'($urandom);
    y  = 16'($urandom);
    s  = 1'($urandom);
    ci = 1'($urandom);
    issue(i, x, y, s, ci, model(x, y, s, ci), acc);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (sbq[i].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk($sformatf("drain_timeout%0d", i), 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      last_done[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out%0d", i), 32'(out_v[i]), 32'd0);
      chk($sformatf("rst_cout%0d", i), 32'(cout_v[i]), 32'd0);
      chk($sformatf("rst_ovf%0d", i), 32'(ovf_v[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(ready_v[i]), 32'd1);
    end

    issue(0, 16'h1234, 16'h0FCD, 0, 0, mk(16'h2201, 0, 0), acc);
    drain(0);
    issue(0, 16'hFFFF, 16'h0001, 0, 0, mk(16'h0000, 1, 0), acc);
    drain(0);
    issue(0, 16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1), acc);
    drain(0);
    issue(0, 16'h0005, 16'h0007, 1, 0, mk(16'hFFFE, 0, 0), acc);
    drain(0);
    issue(0, 16'h8000, 16'h0001, 1, 0, mk(16'h7FFF, 1, 1), acc);
    drain(0);
    issue(0, 16'h0010, 16'h0001, 1, 1, mk(16'h000E, 1, 0), acc);
    drain(0);
    chk("hold_out_idle", 32'(out_v[0]), 32'h000E);

    // start and operands toggled while RUN must be ignored
    issue(0, 16'hA5A5, 16'h1111, 0, 1, mk(16'hB6B7, 0, 0), acc);
    start_v[0] = 1'b1;
    a = 16'($urandom); b = 16'($urandom); sub = 1'b1; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_v[0] = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    drain(0);

    // back-to-back: second accept directly out of DONE
    issue(0, 16'h0101, 16'h0202, 0, 0, mk(16'h0303, 0, 0), acc);
    issue(0, 16'h4000, 16'h4000, 0, 0, mk(16'h8000, 0, 1), acc2);
    chk("b2b_no_idle", 32'(acc2 - last_done[0]), 32'd1);
    chk("b2b_spacing", 32'(acc2 - acc), 32'd5);
    drain(0);

    // reset during the second RUN cycle aborts silently
    issue(0, 16'h1357, 16'h2468, 0, 0, mk(16'h379F, 0, 0), acc);
    @(posedge clk);
    #1 rst = 1'b1;
    sbq[0].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out", 32'(out_v[0]), 32'd0);
    chk("abort_cout", 32'(cout_v[0]), 32'd0);
    chk("abort_ovf", 32'(ovf_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_ready", 32'(ready_v[0]), 32'd1);
    repeat (8) @(negedge clk);

    issue(1, 16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1), acc);
    drain(1);
    issue(2, 16'h8000, 16'h0001, 1, 0, mk(16'h7FFF, 1, 1), acc);
    drain(2);

    for (int n = 0; n < 40; n++) begin
      rnd_op(0, acc);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain(0);
    for (int n = 0; n < 12; n++) begin
      rnd_op(1, acc);
      rnd_op(2, acc);
    end
    drain(1);
    drain(2);

    for (int i = 0; i < 3; i++)
      chk($sformatf("sb_empty%0d", i), 32'(sbq[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
